// File: rtl/red_pitaya_sort_pulse_pkg.sv
// Shared types and constants for the sort-pulse electrode driver:
// FSM state encoding, register map offsets and register reset defaults.
package red_pitaya_sort_pulse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DELAY   = 3'd1,
    ST_HIGH    = 3'd2,
    ST_LOW     = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  localparam logic [19:0] ADDR_CTRL      = 20'h00000;
  localparam logic [19:0] ADDR_DELAY     = 20'h00004;
  localparam logic [19:0] ADDR_HALF      = 20'h00008;
  localparam logic [19:0] ADDR_NCYC      = 20'h0000C;
  localparam logic [19:0] ADDR_AMP       = 20'h00010;
  localparam logic [19:0] ADDR_HOLDOFF   = 20'h00014;
  localparam logic [19:0] ADDR_TRIG_CNT  = 20'h00100;
  localparam logic [19:0] ADDR_MISS_CNT  = 20'h00104;

  localparam logic        RST_ENABLE      = 1'b1;
  localparam logic [31:0] RST_DELAY       = 32'd0;
  localparam logic [31:0] RST_HALF_PERIOD = 32'd62;
  localparam logic [31:0] RST_N_CYCLES    = 32'd10;
  localparam logic [31:0] RST_AMPLITUDE   = 32'd4096;
  localparam logic [31:0] RST_HOLDOFF     = 32'd125000;

endpackage

// File: rtl/sort_pulse_regs.sv
// System-bus register file for the sort-pulse driver: live config, per-burst
// shadow copies, trigger/missed counters and the registered read path.
module sort_pulse_regs
  import red_pitaya_sort_pulse_pkg::*;
#(
  parameter int DW = 14,
  parameter int CW = 32
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [31:0]          sys_addr,
  input  logic [31:0]          sys_wdata,
  input  logic [3:0]           sys_sel,
  input  logic                 sys_wen,
  input  logic                 sys_ren,
  output logic [31:0]          sys_rdata,
  output logic                 sys_ack,
  input  logic                 start_i,
  input  logic                 missed_i,
  input  state_e               state_i,
  input  logic                 busy_i,
  output logic                 enable_o,
  output logic                 abort_o,
  output logic [CW-1:0]        sh_delay_o,
  output logic [CW-1:0]        sh_half_o,
  output logic [CW-1:0]        sh_ncyc_o,
  output logic [CW-1:0]        sh_holdoff_o,
  output logic signed [DW-1:0] sh_amp_o
);

  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

  logic [19:0] addr_s;
  logic        abort_s, clr_s, unused_s;
  logic        enable_q, enable_d, ack_q, ack_d;
  logic [CW-1:0] delay_q, delay_d, half_q, half_d, ncyc_q, ncyc_d, hold_q, hold_d;
  logic [CW-1:0] sh_delay_q, sh_delay_d, sh_half_q, sh_half_d;
  logic [CW-1:0] sh_ncyc_q, sh_ncyc_d, sh_hold_q, sh_hold_d;
  logic [CW-1:0] trig_cnt_q, trig_cnt_d, miss_cnt_q, miss_cnt_d;
  logic signed [DW-1:0] amp_q, amp_d, sh_amp_q, sh_amp_d;
  logic [31:0] rdata_q, rdata_d;

  assign addr_s   = sys_addr[19:0];
  assign unused_s = ^{sys_sel, sys_addr[31:20]};

  // Bus write decode; abort and counter clear are single-cycle strobes.
  always_comb begin
    enable_d = enable_q;
    delay_d  = delay_q;
    half_d   = half_q;
    ncyc_d   = ncyc_q;
    amp_d    = amp_q;
    hold_d   = hold_q;
    abort_s  = 1'b0;
    clr_s    = 1'b0;
    if (sys_wen) begin
      case (addr_s)
        ADDR_CTRL: begin
          enable_d = sys_wdata[0];
          abort_s  = sys_wdata[1];
          clr_s    = sys_wdata[2];
        end
        ADDR_DELAY:   delay_d = CW'(sys_wdata);
        ADDR_HALF:    half_d  = CW'(sys_wdata);
        ADDR_NCYC:    ncyc_d  = CW'(sys_wdata);
        ADDR_AMP:     amp_d   = sys_wdata[DW-1:0];
        ADDR_HOLDOFF: hold_d  = CW'(sys_wdata);
        default:      abort_s = 1'b0;
      endcase
    end else begin
      abort_s = 1'b0;
    end
  end

  // Shadow capture on burst start; counters where a clear beats an increment.
  always_comb begin
    sh_delay_d = sh_delay_q;
    sh_half_d  = sh_half_q;
    sh_ncyc_d  = sh_ncyc_q;
    sh_amp_d   = sh_amp_q;
    sh_hold_d  = sh_hold_q;
    if (start_i) begin
      sh_delay_d = delay_q;
      sh_half_d  = half_q;
      sh_ncyc_d  = ncyc_q;
      sh_amp_d   = amp_q;
      sh_hold_d  = hold_q;
    end else begin
      sh_delay_d = sh_delay_q;
    end
    if (clr_s)         trig_cnt_d = '0;
    else if (start_i)  trig_cnt_d = trig_cnt_q + ONE_C;
    else               trig_cnt_d = trig_cnt_q;
    if (clr_s)         miss_cnt_d = '0;
    else if (missed_i) miss_cnt_d = miss_cnt_q + ONE_C;
    else               miss_cnt_d = miss_cnt_q;
  end

  // Read mux; data and ack both appear one clock after the request.
  always_comb begin
    rdata_d = 32'd0;
    ack_d   = sys_wen | sys_ren;
    if (sys_ren) begin
      case (addr_s)
        ADDR_CTRL:     rdata_d = {24'd0, 1'b0, state_i, 1'b0, busy_i, 1'b0, enable_q};
        ADDR_DELAY:    rdata_d = 32'(delay_q);
        ADDR_HALF:     rdata_d = 32'(half_q);
        ADDR_NCYC:     rdata_d = 32'(ncyc_q);
        ADDR_AMP:      rdata_d = 32'(amp_q);
        ADDR_HOLDOFF:  rdata_d = 32'(hold_q);
        ADDR_TRIG_CNT: rdata_d = 32'(trig_cnt_q);
        ADDR_MISS_CNT: rdata_d = 32'(miss_cnt_q);
        default:       rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  // Register state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      enable_q   <= RST_ENABLE;
      delay_q    <= CW'(RST_DELAY);
      half_q     <= CW'(RST_HALF_PERIOD);
      ncyc_q     <= CW'(RST_N_CYCLES);
      amp_q      <= DW'(RST_AMPLITUDE);
      hold_q     <= CW'(RST_HOLDOFF);
      sh_delay_q <= CW'(RST_DELAY);
      sh_half_q  <= CW'(RST_HALF_PERIOD);
      sh_ncyc_q  <= CW'(RST_N_CYCLES);
      sh_amp_q   <= DW'(RST_AMPLITUDE);
      sh_hold_q  <= CW'(RST_HOLDOFF);
      trig_cnt_q <= '0;
      miss_cnt_q <= '0;
      rdata_q    <= 32'd0;
      ack_q      <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      delay_q    <= delay_d;
      half_q     <= half_d;
      ncyc_q     <= ncyc_d;
      amp_q      <= amp_d;
      hold_q     <= hold_d;
      sh_delay_q <= sh_delay_d;
      sh_half_q  <= sh_half_d;
      sh_ncyc_q  <= sh_ncyc_d;
      sh_amp_q   <= sh_amp_d;
      sh_hold_q  <= sh_hold_d;
      trig_cnt_q <= trig_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
    end
  end

  assign sys_rdata    = rdata_q;
  assign sys_ack      = ack_q;
  assign enable_o     = enable_q;
  assign abort_o      = abort_s;
  assign sh_delay_o   = sh_delay_q;
  assign sh_half_o    = sh_half_q;
  assign sh_ncyc_o    = sh_ncyc_q;
  assign sh_holdoff_o = sh_hold_q;
  assign sh_amp_o     = sh_amp_q;

endmodule

// File: rtl/red_pitaya_sort_pulse.sv
// Sort-pulse electrode driver: trigger edge -> delay -> N square periods -> hold-off.
// Define SORT_PULSE_BIPOLAR_EN for a saturated -amplitude LOW phase (default: LOW = 0).
module red_pitaya_sort_pulse
  import red_pitaya_sort_pulse_pkg::*;
#(
  parameter int DW = 14,
  parameter int CW = 32
) (
  input  logic                 adc_clk_i,
  input  logic                 adc_rstn_i,
  input  logic                 trig_i,
  output logic signed [DW-1:0] dac_o,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic [31:0]          sys_addr,
  input  logic [31:0]          sys_wdata,
  input  logic [3:0]           sys_sel,
  input  logic                 sys_wen,
  input  logic                 sys_ren,
  output logic [31:0]          sys_rdata,
  output logic                 sys_err,
  output logic                 sys_ack
);

  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cyc_q, cyc_d;
  logic signed [DW-1:0] dac_q, dac_d, low_s, sh_amp_s;
  logic [CW-1:0] sh_delay_s, sh_half_s, sh_ncyc_s, sh_hold_s;
  logic trig_q, trig_prev_q, edge_s, start_s, missed_s, enable_s, abort_s;
  logic busy_q, busy_d, done_q, done_d;

  // Lengths of 0 and 1 both mean a single cycle.
  function automatic logic phase_last(input logic [CW-1:0] cnt, input logic [CW-1:0] len);
    return (len <= ONE_C) || (cnt == (len - ONE_C));
  endfunction

`ifdef SORT_PULSE_BIPOLAR_EN
  function automatic logic signed [DW-1:0] sat_neg(input logic signed [DW-1:0] a);
    if (a == {1'b1, {(DW-1){1'b0}}}) return {1'b0, {(DW-1){1'b1}}};
    else                             return -a;
  endfunction
  assign low_s = sat_neg(sh_amp_s);
`else
  assign low_s = '0;
`endif

  assign edge_s   = trig_q & ~trig_prev_q;
  assign start_s  = edge_s & enable_s & (state_q == ST_IDLE) & ~abort_s;
  assign missed_s = edge_s & ((state_q != ST_IDLE) | abort_s);

  sort_pulse_regs #(.DW(DW), .CW(CW)) u_regs (
    .clk_i        (adc_clk_i),
    .rstn_i       (adc_rstn_i),
    .sys_addr     (sys_addr),
    .sys_wdata    (sys_wdata),
    .sys_sel      (sys_sel),
    .sys_wen      (sys_wen),
    .sys_ren      (sys_ren),
    .sys_rdata    (sys_rdata),
    .sys_ack      (sys_ack),
    .start_i      (start_s),
    .missed_i     (missed_s),
    .state_i      (state_q),
    .busy_i       (busy_q),
    .enable_o     (enable_s),
    .abort_o      (abort_s),
    .sh_delay_o   (sh_delay_s),
    .sh_half_o    (sh_half_s),
    .sh_ncyc_o    (sh_ncyc_s),
    .sh_holdoff_o (sh_hold_s),
    .sh_amp_o     (sh_amp_s)
  );

  // Next-state logic; dac follows the current state so it lags it by one clock.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE_C;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        cyc_d = '0;
        if (start_s) state_d = ST_DELAY;
        else         state_d = ST_IDLE;
      end
      ST_DELAY: begin
        if (cnt_q == sh_delay_s) begin
          cnt_d = '0;
          if (sh_ncyc_s == '0) state_d = ST_HOLDOFF;
          else                 state_d = ST_HIGH;
        end else begin
          state_d = ST_DELAY;
        end
      end
      ST_HIGH: begin
        if (phase_last(cnt_q, sh_half_s)) begin
          cnt_d   = '0;
          state_d = ST_LOW;
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (phase_last(cnt_q, sh_half_s)) begin
          cnt_d = '0;
          if ((cyc_q + ONE_C) < sh_ncyc_s) begin
            cyc_d   = cyc_q + ONE_C;
            state_d = ST_HIGH;
          end else begin
            state_d = ST_HOLDOFF;
          end
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_HOLDOFF: begin
        if (phase_last(cnt_q, sh_hold_s)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_HOLDOFF;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_s) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      done_d  = done_d;
    end
    busy_d = (state_d != ST_IDLE);
    if (abort_s) begin
      dac_d = '0;
    end else begin
      case (state_q)
        ST_HIGH: dac_d = sh_amp_s;
        ST_LOW:  dac_d = low_s;
        default: dac_d = '0;
      endcase
    end
  end

  // FSM, trigger synchroniser and registered outputs.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cyc_q       <= '0;
      dac_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trig_q      <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      dac_q       <= dac_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      trig_q      <= trig_i;
      trig_prev_q <= trig_q;
    end
  end

  assign dac_o   = dac_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sys_err = 1'b0;

endmodule

// File: tb/tb_red_pitaya_sort_pulse.sv
// Scoreboard bench: stimulus queues expected dac edges, done pulses and bus acks;
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_red_pitaya_sort_pulse;

  localparam int DW = 14;
  localparam logic [31:0] A_CTRL = 32'h0, A_DELAY = 32'h4, A_HALF = 32'h8, A_NCYC = 32'hC;
  localparam logic [31:0] A_AMP = 32'h10, A_HOLD = 32'h14, A_TRIG = 32'h100, A_MISS = 32'h104;

  logic clk = 1'b0;
  logic rst_n, trig_i, sys_wen, sys_ren, busy_o, done_o, sys_err, sys_ack;
  logic signed [DW-1:0] dac_o;
  logic [31:0] sys_addr, sys_wdata, sys_rdata;
  logic [3:0] sys_sel;

  typedef struct { int kind; int cyc; int val; } ev_t;
  typedef struct { int cyc; bit rd; int data; } ack_t;
  ev_t  ev_q[$];
  ack_t ack_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int prev_dac = 0;
  bit mon_en = 1'b0;

  red_pitaya_sort_pulse #(.DW(DW), .CW(32)) dut (
    .adc_clk_i (clk), .adc_rstn_i (rst_n), .trig_i (trig_i), .dac_o (dac_o),
    .busy_o (busy_o), .done_o (done_o), .sys_addr (sys_addr), .sys_wdata (sys_wdata),
    .sys_sel (sys_sel), .sys_wen (sys_wen), .sys_ren (sys_ren), .sys_rdata (sys_rdata),
    .sys_err (sys_err), .sys_ack (sys_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int low_of(input int a);
`ifdef SORT_PULSE_BIPOLAR_EN
    return (a == -8192) ? 8191 : -a;
`else
    return 0;
`endif
  endfunction

  task automatic mon_ev(input int kind, input int val);
    ev_t e;
    if (ev_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d value %0d at cycle %0d expected none", kind, val, cyc);
    end else begin
      e = ev_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("event_value", val, e.val);
    end
  endtask

  task automatic mon_ack();
    ack_t a;
    if (ack_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
    end else begin
      a = ack_q.pop_front();
      chk("ack_cycle", cyc, a.cyc);
      if (a.rd) chk("read_data", int'(sys_rdata), a.data);
    end
  endtask

  // Monitor: dac transitions, done pulses and bus acks.
  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(dac_o) != prev_dac) mon_ev(0, int'(dac_o));
      if (done_o) mon_ev(1, 1);
      if (sys_ack) mon_ack();
    end
    prev_dac = int'(dac_o);
  end

  // Reference waveform: trigger sampled at clock k.
  task automatic push_burst(input int k, input int d, input int h, input int n,
                            input int amp, input int hold);
    int he, hoe, t0, total, v, pv;
    he = (h == 0) ? 1 : h;
    hoe = (hold == 0) ? 1 : hold;
    t0 = k + 3 + d;
    total = 2 * n * he;
    pv = 0;
    for (int t = t0; t <= t0 + total; t++) begin
      v = (t - t0 < total) ? ((((t - t0) % (2 * he)) < he) ? amp : low_of(amp)) : 0;
      if (v != pv) ev_q.push_back('{0, t, v});
      pv = v;
    end
    ev_q.push_back('{1, t0 - 1 + total + hoe, 1});
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    ack_q.push_back('{cyc + 1, 1'b0, 0});
    @(negedge clk);
    sys_wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input int exp);
    sys_addr = a; sys_ren = 1'b1;
    ack_q.push_back('{cyc + 1, 1'b1, exp});
    @(negedge clk);
    sys_ren = 1'b0;
  endtask

  task automatic cfg(input int d, input int h, input int n, input int amp, input int hold);
    bus_wr(A_DELAY, d); bus_wr(A_HALF, h); bus_wr(A_NCYC, n);
    bus_wr(A_AMP, amp); bus_wr(A_HOLD, hold);
  endtask

  task automatic trigger(input int k);
    while (cyc < k - 1) @(negedge clk);
    trig_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    trig_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (ev_q.size() != 0 || ack_q.size() != 0); i++) @(negedge clk);
    if (ev_q.size() != 0 || ack_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d events %0d acks pending expected 0", ev_q.size(), ack_q.size());
      ev_q.delete(); ack_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  int k;

  initial begin
    rst_n = 1'b0; trig_i = 1'b0; sys_wen = 1'b0; sys_ren = 1'b0;
    sys_addr = 32'h0; sys_wdata = 32'h0; sys_sel = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_dac", int'(dac_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_ack", int'(sys_ack), 0);
    chk("rst_err", int'(sys_err), 0);
    chk("rst_rdata", int'(sys_rdata), 0);
    rst_n = 1'b1; mon_en = 1'b1;
    @(negedge clk);

    // Reset defaults of the register map.
    bus_rd(A_CTRL, 1); bus_rd(A_DELAY, 0); bus_rd(A_HALF, 62); bus_rd(A_NCYC, 10);
    bus_rd(A_AMP, 4096); bus_rd(A_HOLD, 125000); bus_rd(A_TRIG, 0); bus_rd(A_MISS, 0);
    drain(20);

    // Basic burst.
    cfg(3, 2, 2, 1000, 6);
    k = cyc + 3; push_burst(k, 3, 2, 2, 1000, 6); trigger(k);
    chk("busy_in_burst", int'(busy_o), 1);
    drain(100);
    bus_rd(A_TRIG, 1);

    // Second edge during hold-off is dropped.
    k = cyc + 3; push_burst(k, 3, 2, 2, 1000, 6); trigger(k);
    trigger(k + 15);
    drain(100);
    bus_rd(A_MISS, 1);
    k = cyc + 3; push_burst(k, 3, 2, 2, 1000, 6); trigger(k);
    drain(100);
    bus_rd(A_TRIG, 3);

    // Bus basics.
    bus_wr(A_HALF, 5); bus_rd(A_HALF, 5); bus_rd(32'h200, 0);
    drain(20);

    // Most negative amplitude.
    cfg(0, 2, 1, 32'hFFFF_E000, 3);
    bus_rd(A_AMP, -8192);
    k = cyc + 3; push_burst(k, 0, 2, 1, -8192, 3); trigger(k);
    drain(100);

    // n_cycles=0 / half_period=0 corners.
    cfg(0, 0, 0, 1000, 6);
    k = cyc + 3; push_burst(k, 0, 0, 0, 1000, 6); trigger(k);
    drain(100);
    bus_wr(A_NCYC, 1);
    k = cyc + 3; push_burst(k, 0, 0, 1, 1000, 6); trigger(k);
    drain(100);

    // Amplitude write mid-burst only affects the next burst.
    cfg(1, 3, 2, 500, 4);
    k = cyc + 3; push_burst(k, 1, 3, 2, 500, 4); trigger(k);
    bus_wr(A_AMP, 700);
    drain(100);
    k = cyc + 3; push_burst(k, 1, 3, 2, 700, 4); trigger(k);
    drain(100);

    // Disabled: edges ignored and not counted.
    bus_wr(A_CTRL, 0);
    k = cyc + 3; trigger(k);
    repeat (15) @(negedge clk);
    bus_wr(A_CTRL, 1);
    bus_rd(A_TRIG, 8); bus_rd(A_MISS, 1);
    drain(20);

    // Abort in HIGH.
    cfg(0, 4, 2, 1000, 4);
    k = cyc + 3;
    ev_q.push_back('{0, k + 3, 1000});
    ev_q.push_back('{0, k + 4, 0});
    trigger(k);
    while (cyc < k + 3) @(negedge clk);
    bus_wr(A_CTRL, 3);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_dac", int'(dac_o), 0);
    repeat (25) @(negedge clk);
    bus_rd(A_CTRL, 1);
    drain(20);

    // Counter clear.
    bus_rd(A_TRIG, 9);
    bus_wr(A_CTRL, 5);
    bus_rd(A_TRIG, 0); bus_rd(A_MISS, 0);
    drain(20);

    // Async reset mid-burst.
    mon_en = 1'b0;
    k = cyc + 3; trigger(k);
`ifdef SORT_PULSE_BIPOLAR_EN
    while (cyc < k + 3 + 5) @(negedge clk);
`else
    while (cyc < k + 3 + 1) @(negedge clk);
`endif
    chk("pre_reset_dac_nonzero", int'(dac_o != 0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dac", int'(dac_o), 0);
    chk("async_rst_busy", int'(busy_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    bus_rd(A_HALF, 62);
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
